// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the radix-2 shift-add sequential multiplier.
// Magnitude extraction is width-agnostic so any multiplier width up to 64 bits can reuse it.
package seq_mult_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Returns the low w bits of |value| (or value itself when unsigned).
    // |-2^(w-1)| = 2^(w-1) still fits in w unsigned bits, so no extra bit is needed.
    function automatic logic [63:0] abs_w(
        input logic [63:0] value,
        input int unsigned w,
        input logic        is_signed
    );
        logic [63:0] mask;
        logic [63:0] v;
        logic        msb;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        v    = value & mask;
        msb  = |(v & (64'd1 << (w - 1)));
        if (is_signed && msb) begin
            v = (~v + 64'd1) & mask;
        end
        return v;
    endfunction

endpackage

// File: rtl/seq_mult_pw.sv
// Parametrised sequential multiplier: radix-2 shift-add on operand magnitudes,
// sign restored on the final edge, start/busy/done handshake with a held product.
module seq_mult_pw
    import seq_mult_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t               r_state;
    logic [WIDTH-1:0]     r_mag_a;
    logic [WIDTH-1:0]     r_mag_b;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic                 r_done;
    logic [2*WIDTH-1:0]   r_product;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic                 w_neg;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]   w_result;
    logic                 w_last;

    assign w_mag_a = WIDTH'(abs_w(64'(a), WIDTH, signed_mode));
    assign w_mag_b = WIDTH'(abs_w(64'(b), WIDTH, signed_mode));
    assign w_neg   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);

    // The final iteration's partial product is folded in before the sign is applied,
    // so the product register is written exactly once per operation.
    assign w_addend   = r_mag_b[0] ? ({{WIDTH{1'b0}}, r_mag_a} << r_cnt) : '0;
    assign w_acc_next = r_acc + w_addend;
    assign w_result   = r_neg ? (~w_acc_next + 1'b1) : w_acc_next;
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_mag_a   <= '0;
            r_mag_b   <= '0;
            r_neg     <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mag_a <= w_mag_a;
                        r_mag_b <= w_mag_b;
                        r_neg   <= w_neg;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_mag_b <= r_mag_b >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_product <= w_result;
                        r_done    <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy    = (r_state == RUN);
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_seq_mult_pw.sv
// Bench for seq_mult_pw: directed corners plus randomized operations checked against
// a plain-arithmetic reference product, handshake timing and product hold.
module tb_seq_mult_pw;

    localparam int W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             signed_mode;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    int n_vec;
    int n_err;

    seq_mult_pw #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2*W-1:0] ref_prod(input logic sm, input logic [W-1:0] x,
                                                input logic [W-1:0] y);
        longint p;
        if (sm) p = longint'($signed(x)) * longint'($signed(y));
        else    p = longint'(x) * longint'(y);
        return p[2*W-1:0];
    endfunction

    // Count negedges after the accepting edge until done; busy cycles seen before it.
    task automatic wait_done(input bit poke, output int cyc, output int busy_c);
        bit got;
        got    = 1'b0;
        cyc    = 0;
        busy_c = 0;
        while (cyc < 3 * W && !got) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 2) begin
                start = 1'b1;
                a     = W'(7);
                b     = W'(7);
            end else begin
                start = 1'b0;
            end
            if (done) got = 1'b1;
            else if (busy) busy_c++;
        end
        if (!got) cyc = -1;
    endtask

    task automatic quiet_check(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk(tag, 64'(seen), 64'd0);
    endtask

    task automatic run_op(input logic sm, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit poke, input string tag);
        logic [2*W-1:0] exp;
        int cyc;
        int busy_c;
        @(negedge clk);
        start       = 1'b1;
        signed_mode = sm;
        a           = x;
        b           = y;
        exp         = ref_prod(sm, x, y);
        @(posedge clk);
        #1;
        start       = 1'b0;
        a           = W'($urandom);
        b           = W'($urandom);
        signed_mode = 1'($urandom);
        wait_done(poke, cyc, busy_c);
        chk({tag, "_latency"}, 64'(cyc), 64'(W + 1));
        chk({tag, "_busy"}, 64'(busy_c), 64'(W));
        chk({tag, "_product"}, 64'(product), 64'(exp));
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(done), 64'd0);
        chk({tag, "_hold"}, 64'(product), 64'(exp));
        if (poke) quiet_check({tag, "_nodone"}, 3 * W);
    endtask

    initial begin
        int cyc1, cyc2, bc;
        logic [2*W-1:0] p1;
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_product", 64'(product), 64'd0);
        rst_n = 1'b1;

        run_op(1'b0, 4'hF, 4'hF, 1'b0, "umax");
        run_op(1'b1, 4'h8, 4'h8, 1'b0, "s_m8m8");
        run_op(1'b1, 4'hD, 4'h5, 1'b0, "s_m3x5");
        run_op(1'b1, 4'h0, 4'h8, 1'b0, "s_0xm8");
        run_op(1'b0, 4'h2, 4'h3, 1'b1, "busy_start");

        // Back-to-back with start held high across the done cycle.
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; a = 4'h5; b = 4'h6;
        @(posedge clk);
        #1;
        a = 4'h9; b = 4'h9;
        cyc1 = 0;
        while (cyc1 < 3 * W && !done) begin
            @(negedge clk);
            cyc1++;
        end
        p1 = product;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b0, cyc2, bc);
        chk("b2b_lat1", 64'(cyc1), 64'(W + 1));
        chk("b2b_prod1", 64'(p1), 64'h1E);
        chk("b2b_lat2", 64'(cyc2), 64'(W + 1));
        chk("b2b_prod2", 64'(product), 64'h51);

        // Reset in the middle of an operation.
        run_op(1'b0, 4'hF, 4'hF, 1'b0, "pre_rst");
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; a = 4'hF; b = 4'hF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_product", 64'(product), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet_check("midrst_nodone", 3 * W);
        chk("midrst_product_after", 64'(product), 64'd0);
        run_op(1'b0, 4'h3, 4'h4, 1'b0, "post_rst");

        for (int i = 0; i < 200; i++) begin
            run_op(1'($urandom), W'($urandom), W'($urandom), 1'($urandom_range(0, 7) == 0),
                   "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_mult_pw.md
Name: seq_mult_pw

Overview:
- Parametrised sequential multiplier using radix-2 shift-add. It is the successor to the team's fixed 4x4 combinational multiplier shell.
- Supports operand width WIDTH and a per-operation signed or unsigned mode.
- Uses a start/busy/done handshake and holds the result until the next one is written.
- Sits behind a TinyTapeout io_in/io_out shell; the shell is a separate top and is not part of this block.

Parameters:
- WIDTH, 4: operand width in bits, must be 2 or more; product is 2*WIDTH bits.
- CW, $clog2(WIDTH+1): width of the iteration counter; derived, never overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands and product; 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when product is updated.
- product  output  2*WIDTH  last result; held stable between done pulses.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n low forces state=IDLE, busy=0, done=0, product=0, and all internal registers to 0, immediately.
  - This holds mid-operation too: any in-flight result is discarded and done is never produced for it.
  - Deassertion is synchronised externally; the block needs no extra handling.
- States: IDLE, RUN. busy is 1 exactly in RUN and is decoded combinationally from the state register.
- IDLE with start=1 at rising edge E0:
  - Latch mag_a = |a| and mag_b = |b| when signed_mode=1, otherwise a and b unchanged.
  - Latch neg = signed_mode & (a[MSB] ^ b[MSB]).
  - Clear acc (2*WIDTH bits) and set cnt=0; go to RUN.
  - |−2^(WIDTH-1)| = 2^(WIDTH-1) fits in WIDTH unsigned bits, so no extra bit is needed.
- RUN, each edge:
  - If mag_b[0]=1, add mag_a << cnt into acc; then shift mag_b right by 1 and increment cnt.
  - On the edge where cnt == WIDTH-1 (edge E0+WIDTH), write product = neg ? −acc_final : acc_final (2*WIDTH-bit two's complement).
  - On that same edge, set done=1 and return to IDLE.
- Latency: done is high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles after start is sampled. Throughput is one product per WIDTH+1 cycles.
- done is a registered single-cycle pulse, cleared on the next edge unless a new result completes.
- start while busy=1 is ignored, with no queueing. Operand changes during RUN have no effect.
- Back-to-back: start is accepted in the same cycle done is high, because the state is already IDLE. The next done arrives WIDTH+1 cycles later.
- Zero operand: iteration still runs the full WIDTH cycles; product=0, never −0 issues.
- product holds its value until the next completing edge or reset; it is never partially updated.
- Signed range: the product always fits in 2*WIDTH bits; no overflow flag.

Decomposition:
- Package seq_mult_pkg holds:
  - the state enum {IDLE, RUN};
  - the default WIDTH constant;
  - a function abs_w(value, is_signed) returning the WIDTH-bit magnitude.
- No sub-module is needed. The datapath (accumulate, shift, conditional negate) and the 2-state FSM stay in one module.
- The TinyTapeout pin-mapping wrapper is a separate top, tt_seq_mult_shell, and is outside this spec.

Test Plan (WIDTH=4 unless noted):
- Unsigned max: a=15, b=15, signed_mode=0, start pulse → busy high 4 cycles, done pulse 5 cycles after start, product=0xE1 (225), held afterwards.
- Signed corners:
  - a=-8 (0x8), b=-8, signed_mode=1 → product=0x40.
  - a=-3 (0xD), b=5 → product=0xF1 (−15).
  - a=0, b=-8 → product=0x00.
- Start while busy: start a=2, b=3; pulse start=1 with a=7, b=7 two cycles later → a single done, product=0x06; no second done.
- Back-to-back: hold start=1 continuously with a=5, b=6 then a=9, b=9 → done pulses 5 cycles apart; products 0x1E then 0x51.
- Reset mid-op: start a=15, b=15, assert rst_n low for 1 cycle at RUN cycle 2 → busy, done and product drop to 0 immediately; no done follows; a subsequent 3×4 yields 0x0C.
- WIDTH=8 exhaustive compare against reference a*b for both modes (65536×2 cases) → zero mismatches; latency 9 cycles for every case.
